// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder used as the serial adder's arithmetic slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, WIDTH cycles per addition.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is carry_q while the last bit is being added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= carry_q ^ fa_carry;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          if (last_bit) begin
            cnt_q   <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout (cout),
    .ovf  (ovf)
`else
    .cout (cout)
`endif
  );

  // Reference: plain unsigned addition, {cout, sum}
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  // Reference: signed result outside the W-bit two's-complement range
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int sx;
    int sy;
    int s;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = sx + sy + int'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction
`endif

  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input string tag);
    logic [W:0] exp;
    int         k;
    int         busyCycles;
    exp = ref_add(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    k = 1;
    busyCycles = 0;
    while (done !== 1'b1 && k <= 3 * W) begin
      if (busy === 1'b1) busyCycles++;
      @(negedge clk);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s timeout: done=%b after %0d cycles, required 1", tag, done, k);
      return;
    end
    checks++;
    if (k != W + 1) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d required %0d", tag, k, W + 1);
    end
    checks++;
    if (busyCycles != W) begin
      failures++;
      $display("[TB] FAIL %s busy_len: got %0d required %0d", tag, busyCycles, W);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s busy_in_done: got %b required 0", tag, busy);
    end
    checks++;
    if (sum !== exp[W-1:0]) begin
      failures++;
      $display("[TB] FAIL %s sum: got %h required %h", tag, sum, exp[W-1:0]);
    end
    checks++;
    if (cout !== exp[W]) begin
      failures++;
      $display("[TB] FAIL %s cout: got %b required %b", tag, cout, exp[W]);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== ref_ovf(ta, tb, tc)) begin
      failures++;
      $display("[TB] FAIL %s ovf: got %b required %b", tag, ovf, ref_ovf(ta, tb, tc));
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s done_pulse: got %b required 0", tag, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({cout, sum} !== exp) begin
      failures++;
      $display("[TB] FAIL %s hold: got %h required %h", tag, {cout, sum}, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h required all 0",
               busy, done, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_add(8'h35, 8'h1A, 1'b0, "add_35_1a");
    run_add(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_add(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c1");
    run_add(8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_add(8'h80, 8'h80, 1'b0, "add_80_80");
  endtask

  task automatic test_random();
    for (int n = 0; n < 15; n++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_start_during_run();
    logic [W:0]   exp;
    logic [W-1:0] gotSum;
    logic         gotCout;
    int           doneCount;
    int           doneAt;
    exp = ref_add(8'h3C, 8'h99, 1'b1);
    gotSum = '0; gotCout = 1'b0; doneCount = 0; doneAt = -1;
    @(negedge clk);
    a = 8'h3C; b = 8'h99; cin = 1'b1; start = 1'b1;
    for (int i = 1; i <= 2 * W + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        doneCount++;
        if (doneAt < 0) begin
          doneAt = i; gotSum = sum; gotCout = cout;
        end
      end
      if (i == 1) start = 1'b0;
      if (i == 3) begin
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    checks++;
    if (doneCount != 1) begin
      failures++;
      $display("[TB] FAIL restart_done_count: got %0d required 1", doneCount);
    end
    checks++;
    if (doneAt != W + 1) begin
      failures++;
      $display("[TB] FAIL restart_latency: got %0d required %0d", doneAt, W + 1);
    end
    checks++;
    if ({gotCout, gotSum} !== exp) begin
      failures++;
      $display("[TB] FAIL restart_result: got %h required %h", {gotCout, gotSum}, exp);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart_no_queue: busy got %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int doneCount;
    doneCount = 0;
    @(negedge clk);
    a = 8'hAA; b = 8'h77; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      failures++;
      $display("[TB] FAIL midrun_reset_outputs: got busy=%b done=%b cout=%b sum=%h required all 0",
               busy, done, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_reset_ovf: got %b required 0", ovf);
    end
`endif
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount != 0) begin
      failures++;
      $display("[TB] FAIL midrun_no_done: got %0d pulses required 0", doneCount);
    end
    run_add(8'h10, 8'h20, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    logic [W:0] expQ[$];
    logic [W:0] exp;
    int         ops;
    int         lastDone;
    int         i;
    ops = 0; lastDone = -1; i = 0;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    expQ.push_back(ref_add(a, b, cin));
    start = 1'b1;
    while (ops < 3 && i < 10 * (W + 2)) begin
      @(negedge clk);
      i++;
      if (done === 1'b1) begin
        exp = expQ.pop_front();
        checks++;
        if ({cout, sum} !== exp) begin
          failures++;
          $display("[TB] FAIL b2b_result%0d: got %h required %h", ops, {cout, sum}, exp);
        end
        if (lastDone >= 0) begin
          checks++;
          if (i - lastDone != W + 2) begin
            failures++;
            $display("[TB] FAIL b2b_interval: got %0d required %0d", i - lastDone, W + 2);
          end
        end
        lastDone = i;
        ops++;
        if (ops < 3) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
          expQ.push_back(ref_add(a, b, cin));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ops != 3) begin
      failures++;
      $display("[TB] FAIL b2b_ops: got %0d completions required 3", ops);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_idle: busy got %b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
